// File: rtl/spectrum_pkg.sv
// ---------------------------------------------------------------------------
// spectrum_pkg : shared types for the spectrum bar pipeline.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package spectrum_pkg;
  localparam int NUM_BINS   = 16;
  localparam int HEIGHT_W   = 9;
  localparam int MAX_HEIGHT = 479;

  typedef logic [HEIGHT_W-1:0] height_t;
  typedef height_t heights_t [NUM_BINS];

  localparam height_t MAX_HEIGHT_H = height_t'(MAX_HEIGHT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    UPDATE = 2'd2,
    COMMIT = 2'd3
  } sched_state_t;
endpackage

`default_nettype wire

// File: rtl/bar_decay_unit.sv
// ---------------------------------------------------------------------------
// bar_decay_unit : clamp one magnitude and apply peak-hold/decay.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bar_decay_unit
  import spectrum_pkg::*;
#(
  parameter int DECAY_STEP = 4
) (
  input  height_t sample,
  input  height_t old,
  input  logic    decay_en,
  output height_t result
);

  localparam logic signed [HEIGHT_W:0] STEP_S = (HEIGHT_W+1)'(DECAY_STEP);

  height_t                    clamped;
  height_t                    floored;
  logic signed [HEIGHT_W:0]   decayed;

  always_comb begin
    clamped = (sample > MAX_HEIGHT_H) ? MAX_HEIGHT_H : sample;
    // One extra sign bit so old < DECAY_STEP goes negative instead of wrapping.
    decayed = $signed({1'b0, old}) - STEP_S;
    floored = decayed[HEIGHT_W] ? '0 : decayed[HEIGHT_W-1:0];
    result  = (decay_en && (floored > clamped)) ? floored : clamped;
  end

endmodule

`default_nettype wire

// File: rtl/spectrum_frame_scheduler.sv
// ---------------------------------------------------------------------------
// spectrum_frame_scheduler : per-frame fetch, decay and atomic commit of bar
// heights for the VGA bar renderer.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spectrum_frame_scheduler
  import spectrum_pkg::*;
#(
  parameter int ADDR_W     = 13,
  parameter int BANK_W     = 4,
  parameter int DECAY_STEP = 4,
  parameter int FRAME_DIV  = 1
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              frame_end,
  input  logic [BANK_W-1:0] bank_sel,
  input  logic              decay_en,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  height_t           mem_rdata,
  output heights_t          heights,
  output logic              loaded,
  output logic              busy,
  output logic              overrun
);

  localparam int BIN_W = $clog2(NUM_BINS);
  localparam int CNT_W = $clog2(FRAME_DIV + 1);
  localparam int SUM_W = BANK_W + BIN_W + 1;

  sched_state_t      state;
  logic [BIN_W-1:0]  bin;
  logic [BANK_W-1:0] bank;
  logic [CNT_W-1:0]  frame_cnt;
  height_t           sample;
  heights_t          shadow;
  height_t           new_height;

  function automatic logic [ADDR_W-1:0] addr_of(input logic [BANK_W-1:0] b,
                                                input logic [BIN_W-1:0]  i);
    logic [SUM_W-1:0] full;
    full = SUM_W'(b) * SUM_W'(NUM_BINS) + SUM_W'(i);
    return ADDR_W'(full);
  endfunction

  bar_decay_unit #(
    .DECAY_STEP(DECAY_STEP)
  ) u_decay (
    .sample  (sample),
    .old     (heights[bin]),
    .decay_en(decay_en),
    .result  (new_height)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state     <= IDLE;
      bin       <= '0;
      bank      <= '0;
      frame_cnt <= '0;
      sample    <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      loaded    <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < NUM_BINS; i++) begin
        heights[i] <= '0;
        shadow[i]  <= '0;
      end
    end else begin
      loaded <= 1'b0;
      if (frame_end && (state != IDLE))
        overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (frame_end) begin
            if (frame_cnt == CNT_W'(FRAME_DIV - 1)) begin
              frame_cnt <= '0;
              bank      <= bank_sel;
              bin       <= '0;
              mem_addr  <= addr_of(bank_sel, '0);
              mem_req   <= 1'b1;
              busy      <= 1'b1;
              state     <= FETCH;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        FETCH: begin
          if (mem_req && mem_ack) begin
            sample  <= mem_rdata;
            mem_req <= 1'b0;
            state   <= UPDATE;
          end
        end
        UPDATE: begin
          shadow[bin] <= new_height;
          if (bin == BIN_W'(NUM_BINS - 1)) begin
            state <= COMMIT;
          end else begin
            bin      <= bin + 1'b1;
            mem_addr <= addr_of(bank, bin + 1'b1);
            mem_req  <= 1'b1;
            state    <= FETCH;
          end
        end
        COMMIT: begin
          // Whole frame lands on one edge so the renderer never sees a mix.
          heights <= shadow;
          loaded  <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spectrum_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_spectrum_frame_scheduler : scoreboard bench for the frame scheduler.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_spectrum_frame_scheduler;
  import spectrum_pkg::*;

  localparam int ADDR_W = 13;
  localparam int BANK_W = 4;
  localparam int MEM_N  = 1 << ADDR_W;

  logic              CLOCK_50 = 1'b0;
  logic              reset = 1'b1;
  logic              frame_end = 1'b0;
  logic [BANK_W-1:0] bank_sel = '0;
  logic              decay_en = 1'b0;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack = 1'b0;
  height_t           mem_rdata = '0;
  heights_t          heights;
  logic              loaded, busy, overrun;

  logic              fe2 = 1'b0;
  logic              req2, ack2, loaded2, busy2, ovr2;
  logic [ADDR_W-1:0] addr2;
  height_t           rdata2;
  heights_t          heights2;

  height_t mem [MEM_N];

  always #10 CLOCK_50 = ~CLOCK_50;

  spectrum_frame_scheduler #(
    .ADDR_W(ADDR_W), .BANK_W(BANK_W), .DECAY_STEP(4), .FRAME_DIV(1)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .frame_end(frame_end), .bank_sel(bank_sel),
    .decay_en(decay_en), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .heights(heights), .loaded(loaded), .busy(busy),
    .overrun(overrun)
  );

  assign ack2   = req2;
  assign rdata2 = mem[addr2];

  spectrum_frame_scheduler #(
    .ADDR_W(ADDR_W), .BANK_W(BANK_W), .DECAY_STEP(4), .FRAME_DIV(3)
  ) dut_div3 (
    .CLOCK_50(CLOCK_50), .reset(reset), .frame_end(fe2), .bank_sel(4'd1),
    .decay_en(1'b0), .mem_req(req2), .mem_addr(addr2), .mem_ack(ack2),
    .mem_rdata(rdata2), .heights(heights2), .loaded(loaded2), .busy(busy2),
    .overrun(ovr2)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int start_cyc = 0;
  int lcnt = 0;
  int l2cnt = 0;

  typedef struct {
    int lat;
    int h[NUM_BINS];
  } exp_t;

  exp_t               exp_q[$];
  logic [ADDR_W-1:0]  addr_q[$];
  int                 model_h[NUM_BINS];
  exp_t               mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Memory responder: configurable ack latency or ack held high.
  int                delay = 0;
  bit                ack_hold = 1'b0;
  int                waited = 0;
  logic [ADDR_W-1:0] held_addr = '0;

  always @(posedge CLOCK_50) begin
    #1;
    if (reset) begin
      mem_ack = 1'b0;
      waited  = 0;
    end else if (ack_hold) begin
      mem_ack   = 1'b1;
      mem_rdata = mem[mem_addr];
    end else if (mem_req) begin
      if (waited > 0) check("addr_stable", mem_addr, held_addr);
      if (waited == delay) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
        waited    = 0;
      end else begin
        mem_ack = 1'b0;
        if (waited == 0) held_addr = mem_addr;
        waited++;
      end
    end else begin
      mem_ack = 1'b0;
      waited  = 0;
    end
  end

  // Monitor: pops expectations when the DUT reads or commits.
  always @(negedge CLOCK_50) begin
    if (loaded)  lcnt++;
    if (loaded2) l2cnt++;
    if (!reset) begin
      if (mem_req && mem_ack) begin
        if (addr_q.size() == 0) check("unexpected_read", 1, 0);
        else check("mem_addr", mem_addr, addr_q.pop_front());
      end
      if (loaded) begin
        if (exp_q.size() == 0) begin
          check("unexpected_loaded", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.lat >= 0) check("latency", cyc - start_cyc, mon_e.lat);
          check("busy_at_loaded", busy, 0);
          for (int i = 0; i < NUM_BINS; i++)
            check($sformatf("height[%0d]", i), heights[i], mon_e.h[i]);
        end
      end
    end
  end

  // Reference model: whole-frame result from the clamp/decay rules.
  task automatic start_seq(input int bank, input bit dec, input int lat);
    exp_t e;
    int   a, s, o;
    e.lat = lat;
    for (int i = 0; i < NUM_BINS; i++) begin
      a = (bank * NUM_BINS + i) % MEM_N;
      addr_q.push_back(ADDR_W'(a));
      s = (int'(mem[a]) > MAX_HEIGHT) ? MAX_HEIGHT : int'(mem[a]);
      if (dec) begin
        o = model_h[i] - 4;
        if (o < 0) o = 0;
        model_h[i] = (s > o) ? s : o;
      end else begin
        model_h[i] = s;
      end
      e.h[i] = model_h[i];
    end
    exp_q.push_back(e);
    @(posedge CLOCK_50); #1;
    bank_sel  = BANK_W'(bank);
    decay_en  = dec;
    frame_end = 1'b1;
    start_cyc = cyc;
    @(posedge CLOCK_50); #1;
    frame_end = 1'b0;
  endtask

  task automatic wait_done(input bit scramble);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 400) begin
      @(posedge CLOCK_50); #1;
      if (scramble) bank_sel = BANK_W'($urandom);
      n++;
    end
    check("completion_in_time", (n < 400) ? 1 : 0, 1);
    repeat (2) @(posedge CLOCK_50);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int prev, b;
    bit d;
    for (int i = 0; i < MEM_N; i++) mem[i] = height_t'($urandom);
    for (int i = 0; i < NUM_BINS; i++) model_h[i] = 0;

    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_loaded", loaded, 0);
    check("rst_overrun", overrun, 0);
    check("rst_height0", heights[0], 0);
    check("rst_height15", heights[NUM_BINS-1], 0);
    @(posedge CLOCK_50); #1;
    reset = 1'b0;

    // Zero-wait ack, bank 0, bin i = 10*i
    for (int i = 0; i < NUM_BINS; i++) mem[i] = height_t'(10 * i);
    start_seq(0, 1'b0, 34);
    wait_done(1'b0);
    check("t1_height5", heights[5], 50);
    check("t1_overrun", overrun, 0);

    // Two-cycle ack wait, bank 3, bank_sel scrambled mid-sequence
    delay = 2;
    start_seq(3, 1'b0, 66);
    wait_done(1'b1);
    delay = 0;

    // Decay arithmetic
    mem[0] = 9'd100; mem[1] = 9'd2; mem[2] = 9'd511;
    start_seq(0, 1'b0, 34);
    wait_done(1'b0);
    check("t3_height0_raw", heights[0], 100);
    check("t3_height2_clamp", heights[2], 479);
    mem[0] = 9'd20; mem[1] = 9'd0;
    start_seq(0, 1'b1, 34);
    wait_done(1'b0);
    check("t3_decay_96", heights[0], 96);
    check("t3_floor_0", heights[1], 0);
    start_seq(0, 1'b1, 34);
    wait_done(1'b0);
    check("t3_decay_92", heights[0], 92);

    // frame_end while busy
    prev = lcnt;
    start_seq(7, 1'b0, 34);
    repeat (3) @(posedge CLOCK_50);
    #1 frame_end = 1'b1;
    @(posedge CLOCK_50); #1 frame_end = 1'b0;
    wait_done(1'b0);
    repeat (40) @(posedge CLOCK_50);
    check("t4_overrun", overrun, 1);
    check("t4_one_loaded", lcnt - prev, 1);

    // Randomized frames
    for (int k = 0; k < 8; k++) begin
      b = $urandom_range(0, 15);
      d = 1'($urandom);
      delay = $urandom_range(0, 3);
      ack_hold = (delay == 0) && ($urandom_range(0, 1) == 1);
      for (int i = 0; i < NUM_BINS; i++) mem[b * NUM_BINS + i] = height_t'($urandom);
      start_seq(b, d, -1);
      wait_done(1'b1);
      repeat ($urandom_range(0, 5)) @(posedge CLOCK_50);
    end
    ack_hold = 1'b0;

    // Reset during FETCH of bin 7
    delay = 1;
    prev = lcnt;
    start_seq(5, 1'b0, -1);
    begin
      int n = 0;
      @(negedge CLOCK_50);
      while (!(mem_req && mem_addr == ADDR_W'(5 * NUM_BINS + 7)) && n < 200) begin
        @(negedge CLOCK_50);
        n++;
      end
      check("t6_reach_bin7", (n < 200) ? 1 : 0, 1);
    end
    reset = 1'b1;
    exp_q.delete();
    addr_q.delete();
    for (int i = 0; i < NUM_BINS; i++) model_h[i] = 0;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check("t6_mem_req", mem_req, 0);
    check("t6_busy", busy, 0);
    check("t6_overrun", overrun, 0);
    check("t6_height0", heights[0], 0);
    check("t6_height7", heights[7], 0);
    @(posedge CLOCK_50); #1 reset = 1'b0;
    delay = 0;
    repeat (40) @(posedge CLOCK_50);
    check("t6_no_loaded", lcnt - prev, 0);

    // Normal operation after the abort
    start_seq(2, 1'b1, 34);
    wait_done(1'b0);

    // FRAME_DIV=3 instance: sequences on the 3rd and 6th frame_end only
    for (int k = 1; k <= 6; k++) begin
      prev = l2cnt;
      @(posedge CLOCK_50); #1 fe2 = 1'b1;
      @(posedge CLOCK_50); #1 fe2 = 1'b0;
      repeat (40) @(posedge CLOCK_50);
      check($sformatf("div3_pulse%0d", k), l2cnt - prev, (k % 3 == 0) ? 1 : 0);
    end

    check("queues_drained", exp_q.size() + addr_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
